cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the six Common Data Bus (CDB) lanes among the functional-unit completion ports. Each cycle it grants up to CDB_WIDTH requesting units and packs their results onto the lanes. The lanes are registered, so the next cycle drives cdb_broadcast, PR/AR tags and values to the map table, reservation stations and ROB. Granted requesters are acknowledged combinationally in the same cycle. Ungranted requesters hold their request.

---
 rtl/cdb_arbiter_if.sv | 27 ++
 rtl/cdb_arbiter.sv | 104 ++++++++++
 tb/tb_cdb_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: functional-unit completion ports in, CDB lanes out.
// master = functional-unit / consumer side, slave = the arbiter.
interface cdb_arbiter_if #(
   parameter int NUM_REQ   = 8,
   parameter int CDB_WIDTH = 6
);
   logic                      recover;
   logic [NUM_REQ-1:0]        fu_req;
   logic [7*NUM_REQ-1:0]      fu_pr_tag;
   logic [5*NUM_REQ-1:0]      fu_ar_tag;
   logic [64*NUM_REQ-1:0]     fu_value;
   logic [NUM_REQ-1:0]        fu_grant;
   logic [CDB_WIDTH-1:0]      cdb_broadcast;
   logic [7*CDB_WIDTH-1:0]    cdb_pr_tags;
   logic [5*CDB_WIDTH-1:0]    cdb_ar_tags;
   logic [64*CDB_WIDTH-1:0]   cdb_values;

   modport master (
      output recover, fu_req, fu_pr_tag, fu_ar_tag, fu_value,
      input  fu_grant, cdb_broadcast, cdb_pr_tags, cdb_ar_tags, cdb_values
   );

   modport slave (
      input  recover, fu_req, fu_pr_tag, fu_ar_tag, fu_value,
      output fu_grant, cdb_broadcast, cdb_pr_tags, cdb_ar_tags, cdb_values
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to CDB_WIDTH completing functional units
// per cycle, starting at rr_ptr, and packs their results onto contiguous lanes
// that are registered for broadcast in the following cycle.
module cdb_arbiter #(
   parameter int NUM_REQ   = 8,
   parameter int CDB_WIDTH = 6
) (
   input  logic         clock,
   input  logic         reset,
   cdb_arbiter_if.slave bus
);

   logic [2:0]                r_ptr;
   logic [CDB_WIDTH-1:0]      r_bc;
   logic [7*CDB_WIDTH-1:0]    r_pr;
   logic [5*CDB_WIDTH-1:0]    r_ar;
   logic [64*CDB_WIDTH-1:0]   r_val;

   logic [NUM_REQ-1:0]        w_grant;
   logic [CDB_WIDTH-1:0]      w_bc;
   logic [7*CDB_WIDTH-1:0]    w_pr;
   logic [5*CDB_WIDTH-1:0]    w_ar;
   logic [64*CDB_WIDTH-1:0]   w_val;
   logic [2:0]                w_idx;
   logic [2:0]                w_next_ptr;
   logic                      w_any;
   logic                      w_found;
   int                        w_cnt;
   int                        w_first;
   int                        w_last;

   // Scan requesters from rr_ptr, grant the first CDB_WIDTH, pack lanes and
   // pick the next pointer (first ungranted, else one past the last granted).
   always_comb begin
      w_grant    = '0;
      w_bc       = '0;
      w_pr       = '0;
      w_ar       = '0;
      w_val      = '0;
      w_idx      = '0;
      w_any      = 1'b0;
      w_found    = 1'b0;
      w_cnt      = 0;
      w_first    = 0;
      w_last     = 0;
      w_next_ptr = r_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = 3'((int'(r_ptr) + k) % NUM_REQ);
         if (bus.fu_req[w_idx]) begin
            w_any = 1'b1;
            if (w_cnt < CDB_WIDTH) begin
               w_grant[w_idx]          = 1'b1;
               w_bc[w_cnt]             = 1'b1;
               w_pr[w_cnt*7 +: 7]      = bus.fu_pr_tag[w_idx*7 +: 7];
               w_ar[w_cnt*5 +: 5]      = bus.fu_ar_tag[w_idx*5 +: 5];
               w_val[w_cnt*64 +: 64]   = bus.fu_value[w_idx*64 +: 64];
               w_last                  = int'(w_idx);
               w_cnt                   = w_cnt + 1;
            end else if (!w_found) begin
               w_found = 1'b1;
               w_first = int'(w_idx);
            end
         end
      end
      if (!w_any)
         w_next_ptr = r_ptr;
      else if (w_found)
         w_next_ptr = 3'(w_first);
      else
         w_next_ptr = 3'((w_last + 1) % NUM_REQ);
   end

   // Grants are withheld entirely while resetting or flushing.
   assign bus.fu_grant = (reset || bus.recover) ? '0 : w_grant;

   // Register the lane bank and advance the pointer; a flush clears the lanes
   // but leaves the pointer where it was.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ptr <= '0;
         r_bc  <= '0;
         r_pr  <= '0;
         r_ar  <= '0;
         r_val <= '0;
      end else if (bus.recover) begin
         r_bc  <= '0;
         r_pr  <= '0;
         r_ar  <= '0;
         r_val <= '0;
      end else begin
         r_ptr <= w_next_ptr;
         r_bc  <= w_bc;
         r_pr  <= w_pr;
         r_ar  <= w_ar;
         r_val <= w_val;
      end
   end

   assign bus.cdb_broadcast = r_bc;
   assign bus.cdb_pr_tags   = r_pr;
   assign bus.cdb_ar_tags   = r_ar;
   assign bus.cdb_values    = r_val;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations, then
// randomized functional units checked every cycle against a queue-based model.
module tb_cdb_arbiter;
   localparam int N = 8;
   localparam int W = 6;

   logic clock;
   logic reset;

   cdb_arbiter_if #(.NUM_REQ(N), .CDB_WIDTH(W)) bus ();

   cdb_arbiter #(.NUM_REQ(N), .CDB_WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   bit          req_a [N];
   logic [6:0]  pr_a  [N];
   logic [4:0]  ar_a  [N];
   logic [63:0] val_a [N];

   task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic newp(input int i);
      pr_a[i]  = 7'($urandom);
      ar_a[i]  = 5'($urandom);
      val_a[i] = {$urandom, $urandom};
   endtask

   task automatic set_req(input logic [N-1:0] m);
      for (int i = 0; i < N; i++) req_a[i] = m[i];
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.fu_req[i]            = req_a[i];
         bus.fu_pr_tag[i*7 +: 7]  = pr_a[i];
         bus.fu_ar_tag[i*5 +: 5]  = ar_a[i];
         bus.fu_value[i*64 +: 64] = val_a[i];
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Behavioural model: priority order is a rotation starting at the pointer;
   // the leading W requesters win and fill lanes in that order.
   int                  m_ptr = 0;
   bit                  lanes_known = 1'b0;
   logic [W-1:0]        e_bc;
   logic [7*W-1:0]      e_pr;
   logic [5*W-1:0]      e_ar;
   logic [64*W-1:0]     e_val;
   int                  waits [N];

   always @(negedge clock) begin
      int q[$];
      int ng;
      logic [N-1:0]    eg;
      logic [W-1:0]    nbc;
      logic [7*W-1:0]  npr;
      logic [5*W-1:0]  nar;
      logic [64*W-1:0] nval;
      q = {};
      for (int d = 0; d < N; d++)
         if (bus.fu_req[(m_ptr + d) % N]) q.push_back((m_ptr + d) % N);
      ng   = (q.size() < W) ? q.size() : W;
      eg   = '0;
      nbc  = '0;
      npr  = '0;
      nar  = '0;
      nval = '0;
      for (int n = 0; n < ng; n++) begin
         eg[q[n]]        = 1'b1;
         nbc[n]          = 1'b1;
         npr[n*7 +: 7]   = bus.fu_pr_tag[q[n]*7 +: 7];
         nar[n*5 +: 5]   = bus.fu_ar_tag[q[n]*5 +: 5];
         nval[n*64 +: 64] = bus.fu_value[q[n]*64 +: 64];
      end
      if (reset || bus.recover) eg = '0;
      chk("grant", 384'(bus.fu_grant), 384'(eg));
      if (lanes_known) begin
         chk("broadcast", 384'(bus.cdb_broadcast), 384'(e_bc));
         chk("pr_tags",   384'(bus.cdb_pr_tags),   384'(e_pr));
         chk("ar_tags",   384'(bus.cdb_ar_tags),   384'(e_ar));
         chk("values",    384'(bus.cdb_values),    384'(e_val));
      end
      // starvation bound: a held request may go unserved at most one normal cycle
      for (int i = 0; i < N; i++) begin
         if (reset || !bus.fu_req[i] || eg[i]) waits[i] = 0;
         else if (!bus.recover) begin
            waits[i]++;
            chk($sformatf("starve_fu%0d", i), 384'(waits[i] > 1), 384'(0));
         end
      end
      if (reset) begin
         e_bc = '0; e_pr = '0; e_ar = '0; e_val = '0;
         m_ptr = 0;
         lanes_known = 1'b1;
      end else if (bus.recover) begin
         e_bc = '0; e_pr = '0; e_ar = '0; e_val = '0;
      end else begin
         e_bc = nbc; e_pr = npr; e_ar = nar; e_val = nval;
         if (q.size() > ng)      m_ptr = q[ng];
         else if (q.size() > 0)  m_ptr = (q[ng-1] + 1) % N;
      end
   end

   logic [N-1:0] g;
   bit rc;

   initial begin
      for (int i = 0; i < N; i++) begin
         newp(i);
         waits[i] = 0;
      end
      reset = 1'b1;
      bus.recover = 1'b0;
      set_req(8'hFF);
      drive();
      #2 chk("grant_in_reset", 384'(bus.fu_grant), 384'(0));
      cyc();
      cyc();
      reset = 1'b0;
      set_req(8'h00);
      drive();
      chk("reset_bc",  384'(bus.cdb_broadcast), 384'(0));
      chk("reset_pr",  384'(bus.cdb_pr_tags),   384'(0));
      chk("reset_ar",  384'(bus.cdb_ar_tags),   384'(0));
      chk("reset_val", 384'(bus.cdb_values),    384'(0));
      #1;

      // sparse requests from pointer 0
      for (int i = 0; i < N; i++) newp(i);
      set_req(8'b0101_0010);
      drive();
      #1 chk("sparse_grant", 384'(bus.fu_grant), 384'(8'h52));
      cyc();
      chk("sparse_bc",    384'(bus.cdb_broadcast), 384'(6'b000111));
      chk("sparse_l0_pr", 384'(bus.cdb_pr_tags[6:0]), 384'(pr_a[1]));
      chk("sparse_l1_val",384'(bus.cdb_values[64 +: 64]), 384'(val_a[4]));
      chk("sparse_l2_ar", 384'(bus.cdb_ar_tags[10 +: 5]), 384'(ar_a[6]));
      chk("sparse_hi_zero", 384'(bus.cdb_values[383:192]), 384'(0));

      // wrap from pointer 7
      set_req(8'h80);
      drive();
      #1 chk("wrap_grant", 384'(bus.fu_grant), 384'(8'h80));
      cyc();
      chk("wrap_bc",  384'(bus.cdb_broadcast), 384'(6'b000001));
      chk("wrap_pr",  384'(bus.cdb_pr_tags[6:0]), 384'(pr_a[7]));
      chk("wrap_ar",  384'(bus.cdb_ar_tags[4:0]), 384'(ar_a[7]));
      chk("wrap_val", 384'(bus.cdb_values[63:0]), 384'(val_a[7]));

      // saturation, pointer back at 0
      for (int i = 0; i < N; i++) newp(i);
      set_req(8'hFF);
      drive();
      #1 chk("sat1_grant", 384'(bus.fu_grant), 384'(8'h3F));
      cyc();
      chk("sat1_bc",   384'(bus.cdb_broadcast), 384'(6'h3F));
      chk("sat1_l0",   384'(bus.cdb_values[63:0]), 384'(val_a[0]));
      chk("sat1_l5",   384'(bus.cdb_values[320 +: 64]), 384'(val_a[5]));
      for (int i = 0; i < 6; i++) newp(i);
      drive();
      #1 chk("sat2_grant", 384'(bus.fu_grant), 384'(8'hCF));
      cyc();
      chk("sat2_bc", 384'(bus.cdb_broadcast), 384'(6'h3F));
      chk("sat2_l0", 384'(bus.cdb_values[63:0]), 384'(val_a[6]));
      chk("sat2_l1", 384'(bus.cdb_values[64 +: 64]), 384'(val_a[7]));
      chk("sat2_l2", 384'(bus.cdb_values[128 +: 64]), 384'(val_a[0]));
      chk("sat2_l5", 384'(bus.cdb_values[320 +: 64]), 384'(val_a[3]));

      // pointer 4 -> 3 via a lone FU2 request
      newp(2);
      set_req(8'h04);
      drive();
      #1 chk("to3_grant", 384'(bus.fu_grant), 384'(8'h04));
      cyc();
      chk("to3_l0", 384'(bus.cdb_values[63:0]), 384'(val_a[2]));

      // recover at pointer 3
      for (int i = 0; i < N; i++) newp(i);
      set_req(8'hFF);
      bus.recover = 1'b1;
      drive();
      #1 chk("recover_grant", 384'(bus.fu_grant), 384'(0));
      cyc();
      chk("recover_bc",  384'(bus.cdb_broadcast), 384'(0));
      chk("recover_val", 384'(bus.cdb_values), 384'(0));
      bus.recover = 1'b0;
      drive();
      #1 chk("post_recover_grant", 384'(bus.fu_grant), 384'(8'hF9));
      cyc();
      chk("post_recover_l0", 384'(bus.cdb_values[63:0]), 384'(val_a[3]));

      // reset mid-run with lanes valid at pointer 5
      for (int i = 0; i < N; i++) newp(i);
      set_req(8'h1E);
      drive();
      #1 chk("to5_grant", 384'(bus.fu_grant), 384'(8'h1E));
      cyc();
      chk("to5_bc", 384'(bus.cdb_broadcast), 384'(6'h0F));
      reset = 1'b1;
      set_req(8'h00);
      drive();
      cyc();
      reset = 1'b0;
      chk("midreset_bc", 384'(bus.cdb_broadcast), 384'(0));
      for (int i = 0; i < N; i++) newp(i);
      set_req(8'h21);
      drive();
      #1 chk("midreset_grant", 384'(bus.fu_grant), 384'(8'h21));
      cyc();
      chk("midreset_bc2", 384'(bus.cdb_broadcast), 384'(6'h03));
      chk("midreset_l0",  384'(bus.cdb_values[63:0]), 384'(val_a[0]));
      chk("midreset_l1",  384'(bus.cdb_values[64 +: 64]), 384'(val_a[5]));
      set_req(8'h00);
      drive();

      // randomized functional units obeying the hold-until-granted handshake
      for (int c = 0; c < 3000; c++) begin
         #1;
         g  = bus.fu_grant;
         rc = bus.recover;
         cyc();
         for (int i = 0; i < N; i++) begin
            if (g[i] || !req_a[i] || rc) begin
               newp(i);
               req_a[i] = ($urandom_range(0, 9) < 6);
            end
         end
         bus.recover = ($urandom_range(0, 99) < 8);
         reset       = ($urandom_range(0, 199) == 0);
         drive();
      end

      @(negedge clock);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
